// File: rtl/tmds_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tmds_pkg
//  Description : Shared TMDS definitions (symbol width, control tokens,
//                alignment FSM state type) used by encoder and decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package tmds_pkg;

    localparam int unsigned c_sym_w = 10;

    // Control tokens, bits 9..0, indexed by {C1,C0}
    localparam logic [c_sym_w-1:0] c_tok_c00 = 10'h354;
    localparam logic [c_sym_w-1:0] c_tok_c01 = 10'h0AB;
    localparam logic [c_sym_w-1:0] c_tok_c10 = 10'h154;
    localparam logic [c_sym_w-1:0] c_tok_c11 = 10'h2AB;

    typedef enum logic [1:0] {
        ST_SEARCH    = 2'd0,
        ST_SLIP_HOLD = 2'd1,
        ST_LOCKED    = 2'd2
    } align_state_t;

endpackage
`default_nettype wire

// File: rtl/tmds_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : tmds_decoder_if
//  Description : Symbol input and decoded output bundle of the TMDS decoder.
//                master = symbol source / output consumer, slave = decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface tmds_decoder_if;
    import tmds_pkg::*;

    logic [c_sym_w-1:0] tmds_in;
    logic [7:0]         data_out;
    logic [1:0]         ctrl_out;
    logic               de;
    logic               locked;
    logic               bitslip;

    modport master (
        output tmds_in,
        input  data_out, ctrl_out, de, locked, bitslip
    );

    modport slave (
        input  tmds_in,
        output data_out, ctrl_out, de, locked, bitslip
    );

endinterface
`default_nettype wire

// File: rtl/tmds_symbol_decode.sv
`default_nettype none
// ============================================================================
//  Module      : tmds_symbol_decode
//  Description : Purely combinational classification of one 10-bit TMDS
//                symbol into control token or data, plus data byte decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [c_sym_w-1:0] i_sym,
    output logic               o_is_ctrl,
    output logic [1:0]         o_ctrl,
    output logic [7:0]         o_data
);

    logic [7:0] w_d;

    // Undo the optional inversion applied by the encoder
    assign w_d = i_sym[9] ? ~i_sym[7:0] : i_sym[7:0];

    // Token match and transition-minimised data recovery
    always_comb begin
        o_is_ctrl = 1'b1;
        o_ctrl    = 2'b00;
        case (i_sym)
            c_tok_c00: o_ctrl = 2'b00;
            c_tok_c01: o_ctrl = 2'b01;
            c_tok_c10: o_ctrl = 2'b10;
            c_tok_c11: o_ctrl = 2'b11;
            default:   o_is_ctrl = 1'b0;
        endcase

        o_data    = 8'h00;
        o_data[0] = w_d[0];
        for (int i = 1; i < 8; i++) begin
            o_data[i] = i_sym[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/tmds_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tmds_decoder
//  Description : TMDS channel decoder with word-alignment FSM. Two-stage
//                pipeline (registered symbol, registered outputs); the FSM
//                works on the registered symbol and requests bitslips from
//                the deserializer until a run of control tokens is seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int unsigned CTRL_RUN  = 8,
    parameter int unsigned SLIP_WAIT = 16,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic           clk_pix,
    input  logic           rst_pix,
    tmds_decoder_if.slave  bus
);

    localparam int unsigned c_run_w  = $clog2(CTRL_RUN) + 1;
    localparam int unsigned c_wait_w = $clog2(SLIP_WAIT) + 1;
    localparam int unsigned c_tmo_w  = $clog2(TIMEOUT) + 1;

    // Terminal values: the counter holds the count of symbols already seen,
    // so the current symbol is the last one when the counter equals N-1.
    localparam logic [c_run_w-1:0]  c_run_last  = c_run_w'(CTRL_RUN - 1);
    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(SLIP_WAIT - 1);
    localparam logic [c_tmo_w-1:0]  c_tmo_last  = c_tmo_w'(TIMEOUT - 1);

    logic [c_sym_w-1:0]  r_sym;
    logic                r_vld;
    logic                w_is_ctrl;
    logic [1:0]          w_ctrl;
    logic [7:0]          w_data;

    align_state_t        r_state;
    align_state_t        w_state_nxt;
    logic                w_slip;

    logic [c_run_w-1:0]  r_run;
    logic [c_tmo_w-1:0]  r_timer;
    logic [c_tmo_w-1:0]  r_gap;
    logic [c_wait_w-1:0] r_hold;

    logic [7:0]          r_data;
    logic [1:0]          r_ctrl;
    logic                r_de;
    logic                r_bitslip;

    // Stage 1: capture the incoming symbol; r_vld masks the reset value
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            r_sym <= '0;
            r_vld <= 1'b0;
        end else begin
            r_sym <= bus.tmds_in;
            r_vld <= 1'b1;
        end
    end

    tmds_symbol_decode u_sym_dec (
        .i_sym     (r_sym),
        .o_is_ctrl (w_is_ctrl),
        .o_ctrl    (w_ctrl),
        .o_data    (w_data)
    );

    // Alignment state register
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            r_state <= ST_SEARCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state; completing a run wins over a coincident search timeout
    always_comb begin
        w_state_nxt = r_state;
        w_slip      = 1'b0;
        if (r_vld) begin
            case (r_state)
                ST_SEARCH: begin
                    if (w_is_ctrl && (r_run == c_run_last)) begin
                        w_state_nxt = ST_LOCKED;
                    end else if (r_timer == c_tmo_last) begin
                        w_state_nxt = ST_SLIP_HOLD;
                        w_slip      = 1'b1;
                    end
                end
                ST_SLIP_HOLD: begin
                    if (r_hold == c_wait_last) begin
                        w_state_nxt = ST_SEARCH;
                    end
                end
                ST_LOCKED: begin
                    if (!w_is_ctrl && (r_gap == c_tmo_last)) begin
                        w_state_nxt = ST_SEARCH;
                    end
                end
                default: w_state_nxt = ST_SEARCH;
            endcase
        end
    end

    // Saturating counters; every state change starts the new state from zero
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            r_run   <= '0;
            r_timer <= '0;
            r_gap   <= '0;
            r_hold  <= '0;
        end else if (r_vld) begin
            if (w_state_nxt != r_state) begin
                r_run   <= '0;
                r_timer <= '0;
                r_gap   <= '0;
                r_hold  <= '0;
            end else begin
                case (r_state)
                    ST_SEARCH: begin
                        if (r_timer != '1) r_timer <= r_timer + 1'b1;
                        if (!w_is_ctrl)      r_run <= '0;
                        else if (r_run != '1) r_run <= r_run + 1'b1;
                    end
                    ST_SLIP_HOLD: begin
                        if (r_hold != '1) r_hold <= r_hold + 1'b1;
                    end
                    ST_LOCKED: begin
                        if (w_is_ctrl)        r_gap <= '0;
                        else if (r_gap != '1) r_gap <= r_gap + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Stage 2: decoded outputs; de follows the lock state that this symbol produces
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            r_data    <= '0;
            r_ctrl    <= '0;
            r_de      <= 1'b0;
            r_bitslip <= 1'b0;
        end else begin
            r_bitslip <= w_slip;
            if (r_vld) begin
                if (w_is_ctrl) begin
                    r_ctrl <= w_ctrl;
                    r_de   <= 1'b0;
                end else begin
                    r_data <= w_data;
                    r_de   <= (w_state_nxt == ST_LOCKED);
                end
            end
        end
    end

    assign bus.data_out = r_data;
    assign bus.ctrl_out = r_ctrl;
    assign bus.de       = r_de;
    assign bus.locked   = (r_state == ST_LOCKED);
    assign bus.bitslip  = r_bitslip;

endmodule
`default_nettype wire

// File: tb/tb_tmds_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tmds_decoder
//  Description : Self-checking bench for tmds_decoder: vector table, corner
//                sequences and random stimulus against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tmds_decoder;

    localparam int CTRL_RUN  = 8;
    localparam int SLIP_WAIT = 16;
    localparam int TIMEOUT   = 4096;
    localparam logic [9:0] TOK0 = 10'h354;

    typedef struct {
        logic [7:0] data;
        logic [1:0] ctrl;
        logic       de;
        logic       locked;
        logic       slip;
    } exp_t;

    typedef struct {
        logic [9:0] sym;
        logic [7:0] data;
        logic [1:0] ctrl;
        logic       de;
        logic       locked;
    } vec_t;

    logic clk_pix = 1'b0;
    logic rst_pix = 1'b1;
    tmds_decoder_if bus();

    tmds_decoder #(.CTRL_RUN(CTRL_RUN), .SLIP_WAIT(SLIP_WAIT), .TIMEOUT(TIMEOUT)) dut (
        .clk_pix (clk_pix),
        .rst_pix (rst_pix),
        .bus     (bus)
    );

    always #5 clk_pix = ~clk_pix;

    int checks   = 0;
    int failures = 0;

    // behavioural model state
    bit         m_locked;
    int         m_hold_left, m_seen, m_run, m_gap;
    logic [7:0] m_data;
    logic [1:0] m_ctrl;
    exp_t       exp_q[$];

    // last sampled DUT outputs
    logic [7:0] obs_data;
    logic [1:0] obs_ctrl;
    logic       obs_de, obs_locked, obs_slip;

    function automatic bit is_tok(input logic [9:0] s);
        return (s == 10'h354) || (s == 10'h0AB) || (s == 10'h154) || (s == 10'h2AB);
    endfunction

    function automatic logic [1:0] tok_val(input logic [9:0] s);
        case (s)
            10'h0AB: return 2'b01;
            10'h154: return 2'b10;
            10'h2AB: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [9:0] tok_of(input int idx);
        case (idx)
            1:       return 10'h0AB;
            2:       return 10'h154;
            3:       return 10'h2AB;
            default: return 10'h354;
        endcase
    endfunction

    function automatic logic [7:0] dec_ref(input logic [9:0] s);
        logic [7:0] dd, x;
        dd = s[9] ? ~s[7:0] : s[7:0];
        x  = dd ^ {dd[6:0], 1'b0};
        if (!s[8]) x = x ^ 8'hFE;
        return x;
    endfunction

    // Reference TMDS encoder; inversion flips if the result would be a token
    function automatic logic [9:0] enc(input logic [7:0] d, input logic inv);
        int n1;
        logic xn, iv;
        logic [8:0] qm;
        logic [9:0] s;
        n1 = $countones(d);
        xn = (n1 > 4) || (n1 == 4 && !d[0]);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = ~xn;
        iv = inv;
        s  = {iv, qm[8], iv ? ~qm[7:0] : qm[7:0]};
        if (is_tok(s)) begin
            iv = ~iv;
            s  = {iv, qm[8], iv ? ~qm[7:0] : qm[7:0]};
        end
        return s;
    endfunction

    function automatic logic [9:0] rnd_data();
        return enc(8'($urandom), 1'($urandom));
    endfunction

    function automatic logic [9:0] rot_sym(input logic [9:0] t, input int off);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = t[(i + off) % 10];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_hold_left = 0; m_seen = 0; m_run = 0; m_gap = 0;
        m_data = 8'h00; m_ctrl = 2'b00;
        exp_q.delete();
    endtask

    // Advance the model by one symbol following the alignment rules
    task automatic model_apply(input logic [9:0] s, output exp_t e);
        bit tok, slip;
        tok  = is_tok(s);
        slip = 0;
        if (m_hold_left > 0) begin
            m_hold_left--;
            if (m_hold_left == 0) begin m_seen = 0; m_run = 0; end
        end else if (m_locked) begin
            m_gap = tok ? 0 : m_gap + 1;
            if (m_gap >= TIMEOUT) begin m_locked = 0; m_seen = 0; m_run = 0; end
        end else begin
            m_seen++;
            m_run = tok ? m_run + 1 : 0;
            if (m_run >= CTRL_RUN) begin
                m_locked = 1; m_gap = 0;
            end else if (m_seen >= TIMEOUT) begin
                slip = 1; m_hold_left = SLIP_WAIT;
            end
        end
        if (tok) m_ctrl = tok_val(s);
        else     m_data = dec_ref(s);
        e.data = m_data; e.ctrl = m_ctrl; e.de = !tok && m_locked;
        e.locked = m_locked; e.slip = slip;
    endtask

    // Drive one symbol, wait a cycle, compare the outputs of the previous symbol
    task automatic step(input logic [9:0] s);
        exp_t e;
        model_apply(s, e);
        exp_q.push_back(e);
        bus.tmds_in = s;
        @(negedge clk_pix);
        obs_data = bus.data_out; obs_ctrl = bus.ctrl_out; obs_de = bus.de;
        obs_locked = bus.locked; obs_slip = bus.bitslip;
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            chk("model_data",    32'(obs_data),   32'(e.data));
            chk("model_ctrl",    32'(obs_ctrl),   32'(e.ctrl));
            chk("model_de",      32'(obs_de),     32'(e.de));
            chk("model_locked",  32'(obs_locked), 32'(e.locked));
            chk("model_bitslip", 32'(obs_slip),   32'(e.slip));
        end
    endtask

    // Asynchronous reset pulse; outputs must clear without waiting for a clock
    task automatic do_reset();
        #2 rst_pix = 1'b1;
        #1;
        chk("rst_data",    32'(bus.data_out), 0);
        chk("rst_ctrl",    32'(bus.ctrl_out), 0);
        chk("rst_de",      32'(bus.de),       0);
        chk("rst_locked",  32'(bus.locked),   0);
        chk("rst_bitslip", 32'(bus.bitslip),  0);
        repeat (3) @(negedge clk_pix);
        rst_pix = 1'b0;
        model_reset();
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[9];
        logic [7:0] bytes[5];
        int slips, since, viol, offset, budget;
        bit seen_lock;

        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h5A; bytes[3] = 8'hA5; bytes[4] = 8'h10;
        for (int i = 0; i < 5; i++)
            tbl[i] = '{sym: enc(bytes[i], 1'(i)), data: bytes[i], ctrl: 2'b00, de: 1'b1, locked: 1'b1};
        for (int i = 0; i < 4; i++)
            tbl[5+i] = '{sym: tok_of(i), data: 8'h10, ctrl: 2'(i), de: 1'b0, locked: 1'b1};

        bus.tmds_in = '0;
        model_reset();
        do_reset();

        // Lock, then round-trip bytes and control tokens from the table
        repeat (CTRL_RUN) step(TOK0);
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].sym);
            if (i > 0) begin
                chk("tbl_data",   32'(obs_data),   32'(tbl[i-1].data));
                chk("tbl_ctrl",   32'(obs_ctrl),   32'(tbl[i-1].ctrl));
                chk("tbl_de",     32'(obs_de),     32'(tbl[i-1].de));
                chk("tbl_locked", 32'(obs_locked), 32'(tbl[i-1].locked));
            end
        end
        step(TOK0);
        chk("tbl_data",   32'(obs_data),   32'(tbl[8].data));
        chk("tbl_ctrl",   32'(obs_ctrl),   32'(tbl[8].ctrl));
        chk("tbl_de",     32'(obs_de),     32'(tbl[8].de));
        chk("tbl_locked", 32'(obs_locked), 32'(tbl[8].locked));

        // Loss of lock after TIMEOUT data symbols
        for (int k = 0; k < TIMEOUT; k++) begin
            step(rnd_data());
            if (k == TIMEOUT - 1) chk("lol_still_locked", 32'(obs_locked), 1);
        end
        step(TOK0);
        chk("lol_locked",  32'(obs_locked), 0);
        chk("lol_de",      32'(obs_de),     0);
        chk("lol_bitslip", 32'(obs_slip),   0);

        // Short run must not lock
        do_reset();
        seen_lock = 0;
        repeat (CTRL_RUN - 1) begin step(TOK0); seen_lock |= obs_locked; end
        step(rnd_data()); seen_lock |= obs_locked;
        repeat (CTRL_RUN - 1) begin step(TOK0); seen_lock |= obs_locked; end
        repeat (2) begin step(rnd_data()); seen_lock |= obs_locked; end
        chk("short_run_locked", 32'(seen_lock), 0);

        // Run completes on the same symbol the search timeout expires
        do_reset();
        slips = 0;
        repeat (TIMEOUT - CTRL_RUN) begin step(rnd_data()); slips += int'(obs_slip); end
        repeat (CTRL_RUN) begin step(TOK0); slips += int'(obs_slip); end
        step(rnd_data());
        chk("tie_lock_locked", 32'(obs_locked), 1);
        chk("tie_lock_slips",  32'(slips + int'(obs_slip)), 0);

        // Run one short at the timeout: bitslip, then reset inside SLIP_HOLD
        do_reset();
        repeat (TIMEOUT - CTRL_RUN + 1) step(rnd_data());
        repeat (CTRL_RUN - 1) step(TOK0);
        step(TOK0);
        chk("tie_short_bitslip", 32'(obs_slip),   1);
        chk("tie_short_locked",  32'(obs_locked), 0);
        repeat (5) step(TOK0);
        do_reset();
        slips = 0;
        repeat (CTRL_RUN + 4) begin step(TOK0); slips += int'(obs_slip); end
        chk("hold_rst_slips",  32'(slips), 0);
        chk("hold_rst_locked", 32'(obs_locked), 1);

        // Misalignment: stream rotated by 3 bits, each bitslip advances the window
        do_reset();
        offset = 7; slips = 0; since = 1000; viol = 0;
        budget = 3 * (TIMEOUT + SLIP_WAIT) + CTRL_RUN + 64;
        for (int k = 0; k < budget; k++) begin
            step(rot_sym(TOK0, offset));
            if (obs_slip) begin
                if (since <= SLIP_WAIT) viol++;
                slips++;
                offset = (offset + 1) % 10;
                since  = 0;
            end else begin
                since++;
                if (obs_locked && slips > 0 && since <= SLIP_WAIT) viol++;
            end
            if (obs_locked) break;
        end
        chk("misalign_slips",     32'(slips), 3);
        chk("misalign_locked",    32'(obs_locked), 1);
        chk("misalign_hold_viol", 32'(viol), 0);

        // Random bursts of tokens, encoded data and raw symbols
        do_reset();
        for (int b = 0; b < 400; b++) begin
            int kind, len;
            kind = $urandom_range(0, 9);
            len  = $urandom_range(1, 12);
            for (int j = 0; j < len; j++) begin
                if (kind < 5)      step(tok_of($urandom_range(0, 3)));
                else if (kind < 9) step(rnd_data());
                else               step(10'($urandom));
            end
        end
        step(TOK0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tmds_decoder.md
TMDS_DECODER -- requirements
Module: tmds_decoder

Interface
REQ-001 CTRL_RUN, 8: consecutive control tokens required to declare lock.
REQ-002 SLIP_WAIT, 16: cycles to hold off after a bitslip pulse before searching resumes.
REQ-003 TIMEOUT, 4096: symbols with no control token before a locked link declares loss of lock.
REQ-004 clk_pix  input  1  pixel clock; one 10-bit symbol per cycle.
REQ-005 rst_pix  input  1  reset, asynchronous and active-high.
REQ-006 tmds_in  input  10  deserialized symbol; bit 0 is the first bit on the wire.
REQ-007 data_out  output  8  decoded pixel byte.
REQ-008 ctrl_out  output  2  decoded control bits {C1,C0}.
REQ-009 de  output  1  high when data_out is valid video data.
REQ-010 locked  output  1  word alignment established.
REQ-011 bitslip  output  1  single-cycle request to the deserializer to shift alignment by one bit.

Function
REQ-012 The block SHALL classify each symbol as a control token or data: 0x354 gives ctrl 00, 0x0AB gives 01, 0x154 gives 10, 0x2AB gives 11 (hex values are bits 9..0); every other symbol is data.
REQ-013 The block SHALL decode data symbols as follows:
- d = tmds_in[9] ? ~tmds_in[7:0] : tmds_in[7:0]
- out[0] = d[0]
- for i = 1..7: out[i] = d[i] XOR d[i-1] when tmds_in[8] = 1, else XNOR.
REQ-014 Latency from tmds_in to data_out, ctrl_out and de SHALL be exactly 2 cycles; the stages are register input, then register decoded outputs.
REQ-015 On a control token, de SHALL be 0, ctrl_out SHALL take the token value, and data_out SHALL hold its previous value.
REQ-016 On a data symbol, de SHALL be 1 and ctrl_out SHALL hold its previous value.
REQ-017 While locked = 0, de SHALL be forced to 0.
REQ-018 The alignment FSM SHALL have three states: SEARCH, SLIP_HOLD and LOCKED.
REQ-019 SEARCH behaviour:
- a run counter counts consecutive control tokens;
- reaching CTRL_RUN goes to LOCKED;
- a data symbol clears the run counter;
- TIMEOUT symbols without reaching CTRL_RUN pulse bitslip for 1 cycle and go to SLIP_HOLD.
REQ-020 SLIP_HOLD SHALL ignore input for SLIP_WAIT cycles, then return to SEARCH with all counters cleared.
REQ-021 LOCKED behaviour:
- locked = 1;
- a gap counter clears on every control token;
- the gap counter reaching TIMEOUT with no control token deasserts locked and goes to SEARCH (no bitslip in the same cycle).
REQ-022 The FSM SHALL evaluate the stage-1 registered symbol; locked SHALL change in the same cycle as the corresponding de output.
REQ-023 Counters SHALL saturate and never wrap; counter widths SHALL be sized with $clog2 of their parameter plus 1.
REQ-024 bitslip SHALL be asserted only on the SEARCH to SLIP_HOLD transition, and never on consecutive cycles.
REQ-025 If a control token arrives in the same cycle the SEARCH timeout expires, the token SHALL count and the timeout SHALL be suppressed unless the run is still short of CTRL_RUN.

Reset
REQ-026 Asserting rst_pix SHALL immediately clear all of the following:
- data_out = 0, ctrl_out = 0, de = 0, locked = 0, bitslip = 0;
- the pipeline registers and counters;
- the FSM, which goes to SEARCH.
REQ-027 Reset asserted mid-operation SHALL abort any SLIP_HOLD or LOCKED state with no trailing bitslip pulse.
REQ-028 After reset deassertion, the first valid de SHALL appear no earlier than CTRL_RUN+2 cycles later.

Structure
REQ-029 The four control-token constants and the symbol width SHALL live in the shared tmds_pkg, which the existing TMDS encoder also uses.
REQ-030 Combinational symbol decode (REQ-012, REQ-013) SHALL be a sub-module tmds_symbol_decode; the FSM, counters and pipeline registers SHALL stay in tmds_decoder.

Verification
REQ-031 Round trip: pixel bytes 0x00, 0xFF, 0x5A, 0xA5 and 0x10 from the existing encoder, after 8 × 0x354 tokens -> data_out matches each byte 2 cycles later with de = 1 and locked = 1.
REQ-032 Control decode: tokens 0x354, 0x0AB, 0x154, 0x2AB while locked -> ctrl_out = 00, 01, 10, 11 with de = 0 and data_out unchanged.
REQ-033 Misalignment: control tokens rotated by 3 bits, with the bench model applying each bitslip -> exactly 3 bitslip pulses, each followed by at least 16 cycles of hold, then locked = 1.
REQ-034 Loss of lock: while locked, 4096 consecutive data symbols -> locked falls on the 4096th, de is forced to 0, and no bitslip occurs in that cycle.
REQ-035 Short run: 7 × 0x354, then one data symbol, then 7 × 0x354 -> locked stays 0.
REQ-036 Reset in SLIP_HOLD: assert rst_pix 5 cycles after a bitslip -> all outputs 0 immediately, no further bitslip, FSM in SEARCH after release.
